// File: rtl/seg_scan_driver.sv
// Scan driver for a common-anode 7-segment display: latches converter results into a
// digit history and time-multiplexes it with a blanking lead-in per slot.
// Optional build macro SEG_SCAN_BLINK_OVF_EN makes overflow digits blink (256-frame period).
module seg_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg_in,
    input  logic                  ovf_in,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic                  clr,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg_out,
    output logic                  dp_out
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [6:0]    PAT_E    = 7'b1111001;

    typedef enum logic {S_BLANK, S_DRIVE} state_t;

    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic [IW-1:0]          idx_q;
    logic [NUM_DIGITS-1:0]  an_q;
    logic [6:0]             seg_q;
    logic                   dp_q;

    logic                   pend_q, pend_d;
    logic                   ready_q;
    logic [6:0]             pseg_q;
    logic                   povf_q;
    logic [NUM_DIGITS-1:0]  hval_q;
    logic [NUM_DIGITS-1:0]  hovf_q;
    logic [6:0]             hseg_q [NUM_DIGITS];

    logic                   accept;
    logic                   commit;
    logic                   blink_off;
    logic [6:0]             pat;
    logic [NUM_DIGITS-1:0]  an_sel;

`ifdef SEG_SCAN_BLINK_OVF_EN
    logic [7:0] frm_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm_q <= 8'd0;
        end else if (state_q == S_DRIVE && cnt_q == CNT_LAST && idx_q == IDX_LAST) begin
            frm_q <= frm_q + 8'd1;
        end
    end

    assign blink_off = frm_q[7];
`else
    assign blink_off = 1'b0;
`endif

    // Only one result can wait; it is committed when a new slot begins.
    assign accept = load_valid & ready_q & ~clr;
    assign commit = (cnt_q == '0) & pend_q & ~clr;

    always_comb begin
        pend_d = pend_q;
        if (clr || commit) begin
            pend_d = 1'b0;
        end else if (accept) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q  <= 1'b0;
            ready_q <= 1'b1;
            pseg_q  <= 7'h00;
            povf_q  <= 1'b0;
            hval_q  <= '0;
            hovf_q  <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                hseg_q[i] <= 7'h00;
            end
        end else begin
            pend_q  <= pend_d;
            ready_q <= ~pend_d;
            if (accept) begin
                pseg_q <= seg_in;
                povf_q <= ovf_in;
            end
            if (clr) begin
                hval_q <= '0;
            end else if (commit) begin
                hval_q <= {hval_q[NUM_DIGITS-2:0], 1'b1};
                hovf_q <= {hovf_q[NUM_DIGITS-2:0], povf_q};
                for (int i = NUM_DIGITS - 1; i > 0; i--) begin
                    hseg_q[i] <= hseg_q[i-1];
                end
                hseg_q[0] <= pseg_q;
            end
        end
    end

    always_comb begin
        pat = 7'h00;
        if (hval_q[idx_q]) begin
            pat = hovf_q[idx_q] ? (blink_off ? 7'h00 : PAT_E) : hseg_q[idx_q];
        end
    end

    always_comb begin
        an_sel        = '1;
        an_sel[idx_q] = 1'b0;
    end

    // Outputs are registered from the current state, so they trail it by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_BLANK;
            cnt_q   <= '0;
            idx_q   <= '0;
            an_q    <= '1;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
        end else begin
            an_q  <= (state_q == S_DRIVE) ? an_sel : '1;
            seg_q <= (state_q == S_DRIVE) ? ~pat : 7'h7F;
            dp_q  <= ~((state_q == S_DRIVE) && (idx_q == '0));
            case (state_q)
                S_BLANK: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == BLK_LAST) begin
                        state_q <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= S_BLANK;
                        idx_q   <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_BLANK;
            endcase
        end
    end

    assign load_ready = ready_q;
    assign an         = an_q;
    assign seg_out    = seg_q;
    assign dp_out     = dp_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver (4 digits, 8-cycle slots, 2 blank cycles): a cycle model pushes
// expected outputs each edge, a monitor pops and compares them; directed checks cover the key cases.
module tb_seg_scan_driver;

    localparam int N = 4;
    localparam int R = 8;
    localparam int B = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] seg_in = 7'h00;
    logic       ovf_in = 1'b0;
    logic       load_valid = 1'b0;
    logic       clr = 1'b0;
    logic       load_ready;
    logic [3:0] an;
    logic [6:0] seg_out;
    logic       dp_out;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       rdy;
    } exp_t;

    exp_t sb_q[$];

    // model state
    int         m_cnt = 0;
    int         m_idx = 0;
    logic       m_pend = 1'b0;
    logic       m_ready = 1'b1;
    logic [6:0] m_pseg = 7'h00;
    logic       m_povf = 1'b0;
    logic [7:0] m_fc = 8'd0;
    logic       m_val [N];
    logic       m_ovf [N];
    logic [6:0] m_seg [N];

    seg_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg_in     (seg_in),
        .ovf_in     (ovf_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .clr        (clr),
        .an         (an),
        .seg_out    (seg_out),
        .dp_out     (dp_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [6:0] mpat(input int i);
        logic blink;
`ifdef SEG_SCAN_BLINK_OVF_EN
        blink = m_fc[7];
`else
        blink = 1'b0;
`endif
        if (!m_val[i]) return 7'h00;
        if (m_ovf[i]) return blink ? 7'h00 : 7'b1111001;
        return m_seg[i];
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_idx = 0; m_pend = 1'b0; m_ready = 1'b1; m_fc = 8'd0;
        for (int i = 0; i < N; i++) begin
            m_val[i] = 1'b0; m_ovf[i] = 1'b0; m_seg[i] = 7'h00;
        end
    endtask

    task automatic model_step();
        exp_t e;
        logic drive, acc, com;
        drive  = (m_cnt >= B);
        e.an   = 4'hF;
        if (drive) e.an[m_idx] = 1'b0;
        e.seg  = drive ? ~mpat(m_idx) : 7'h7F;
        e.dp   = !(drive && m_idx == 0);
        acc    = load_valid && m_ready && !clr;
        com    = (m_cnt == 0) && m_pend && !clr;
        if (clr) begin
            for (int i = 0; i < N; i++) m_val[i] = 1'b0;
            m_pend = 1'b0;
        end else if (com) begin
            for (int i = N - 1; i > 0; i--) begin
                m_val[i] = m_val[i-1]; m_ovf[i] = m_ovf[i-1]; m_seg[i] = m_seg[i-1];
            end
            m_val[0] = 1'b1; m_ovf[0] = m_povf; m_seg[0] = m_pseg;
            m_pend = 1'b0;
        end
        if (acc) begin
            m_pend = 1'b1; m_pseg = seg_in; m_povf = ovf_in;
        end
        m_ready = !m_pend;
        e.rdy   = m_ready;
        if (m_cnt == R - 1) begin
            if (m_idx == N - 1) m_fc = m_fc + 8'd1;
            m_idx = (m_idx + 1) % N;
            m_cnt = 0;
        end else begin
            m_cnt = m_cnt + 1;
        end
        sb_q.push_back(e);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("sb_an", 32'(an), 32'(e.an));
                chk("sb_seg", 32'(seg_out), 32'(e.seg));
                chk("sb_dp", 32'(dp_out), 32'(e.dp));
                chk("sb_rdy", 32'(load_ready), 32'(e.rdy));
            end
        end
    end

    task automatic wait_an(input logic [3:0] tgt, input string tag);
        bit ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (an == tgt) begin ok = 1; break; end
        end
        if (!ok) chk(tag, 32'(an), 32'(tgt));
    endtask

    task automatic wait_ready(input string tag);
        bit ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (load_ready) begin ok = 1; break; end
        end
        if (!ok) chk(tag, 32'(load_ready), 32'd1);
    endtask

    task automatic push_load(input logic [6:0] s, input logic o);
        bit ok = 0;
        seg_in = s; ovf_in = o; load_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (load_ready) begin ok = 1; @(negedge clk); break; end
            @(negedge clk);
        end
        if (!ok) chk("accept_timeout", 32'(load_ready), 32'd1);
        load_valid = 1'b0;
    endtask

    initial begin
        logic [6:0] want_seg [4];
        logic [3:0] digit_an [4];
        bit ok;
        want_seg[0] = 7'h19; want_seg[1] = 7'h30; want_seg[2] = 7'h24; want_seg[3] = 7'h79;
        digit_an[0] = 4'hE;  digit_an[1] = 4'hD;  digit_an[2] = 4'hB;  digit_an[3] = 4'h7;

        #12;
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg_out), 32'h7F);
        chk("rst_dp", 32'(dp_out), 32'd1);
        chk("rst_rdy", 32'(load_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        push_load(7'h3F, 1'b0);
        chk("rdy_drop", 32'(load_ready), 32'd0);
        wait_ready("commit0_timeout");
        wait_an(4'hE, "d0_timeout");
        chk("d0_seg", 32'(seg_out), 32'h40);
        chk("d0_dp", 32'(dp_out), 32'd0);

        push_load(7'h06, 1'b0);
        push_load(7'h5B, 1'b0);
        push_load(7'h4F, 1'b0);
        push_load(7'h66, 1'b0);
        wait_ready("commit4_timeout");
        for (int d = 0; d < 4; d++) begin
            wait_an(digit_an[d], "frame_timeout");
            chk("frame_seg", 32'(seg_out), 32'(want_seg[d]));
        end

        push_load(7'h7F, 1'b1);
        wait_ready("ovf_timeout");
        wait_an(4'hE, "ovf_an_timeout");
        chk("ovf_seg", 32'(seg_out), 32'h06);
`ifdef SEG_SCAN_BLINK_OVF_EN
        repeat (140 * N * R) @(negedge clk);
        wait_an(4'hE, "blink_timeout");
        chk("blink_seg", 32'(seg_out), 32'h7F);
`endif

        push_load(7'h5B, 1'b0);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (m_cnt == 0 && m_pend) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) chk("clr_sync_timeout", 32'(m_pend), 32'd1);
        clr = 1'b1; load_valid = 1'b1; seg_in = 7'h4F;
        @(negedge clk);
        clr = 1'b0; load_valid = 1'b0;
        chk("clr_rdy", 32'(load_ready), 32'd1);
        for (int d = 0; d < 4; d++) begin
            wait_an(digit_an[d], "clr_timeout");
            chk("clr_seg", 32'(seg_out), 32'h7F);
        end

        wait_an(4'hB, "rst_mid_timeout");
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_an", 32'(an), 32'hF);
        chk("rst_mid_seg", 32'(seg_out), 32'h7F);
        chk("rst_mid_dp", 32'(dp_out), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (an != 4'hF) begin ok = 1; break; end
        end
        if (!ok) chk("restart_timeout", 32'(an), 32'hE);
        else chk("restart_an", 32'(an), 32'hE);
        repeat (40) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
